// File: rtl/pipe_datamem.sv
// Data memory plus memory-mapped I/O (OUT, synchronised IN, cycle counter) for the pipelined CPU.
// Optional interval timer at 0x8C/0x90/0x94 is built only when PIPE_DATAMEM_TIMER_EN is defined.
module pipe_datamem #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  input  logic [31:0] io_in,
  output logic [31:0] io_out,
  output logic        timer_irq
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [6:0] OFF_OUT   = 7'h00;
  localparam logic [6:0] OFF_IN    = 7'h04;
  localparam logic [6:0] OFF_CYC   = 7'h08;
  localparam logic [6:0] OFF_TLOAD = 7'h0C;
  localparam logic [6:0] OFF_TCNT  = 7'h10;
  localparam logic [6:0] OFF_TSTAT = 7'h14;

  logic [31:0]           mem [WORDS];
  logic [DEPTH_LOG2-1:0] widx;
  logic                  is_io;
  logic [6:0]            off;
  logic [31:0]           sync1;
  logic [31:0]           sync2;
  logic [31:0]           cyc;
  logic [31:0]           io_rd;
  logic                  unused_addr;

  assign widx        = addr[DEPTH_LOG2+1:2];
  assign is_io       = addr[7];
  assign off         = addr[6:0];
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  // RAM store; contents survive reset, and a store under reset is dropped
  always_ff @(posedge clock) begin
    if (resetn && we && !is_io) begin
      mem[widx] <= datain;
    end
  end

  // OUT register, two-flop input synchroniser and free-running cycle counter
  always_ff @(posedge clock) begin
    if (!resetn) begin
      io_out <= 32'd0;
      sync1  <= 32'd0;
      sync2  <= 32'd0;
      cyc    <= 32'd0;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
      if (we && is_io && (off == OFF_CYC)) begin
        cyc <= 32'd0;
      end else begin
        cyc <= cyc + 32'd1;
      end
      if (we && is_io && (off == OFF_OUT)) begin
        io_out <= datain;
      end
    end
  end

`ifdef PIPE_DATAMEM_TIMER_EN
  logic [31:0] tload;
  logic [31:0] tcnt;
  logic        tstat;
  logic        tload_wr;
  logic        expire;

  assign tload_wr  = we && is_io && (off == OFF_TLOAD);
  // a TLOAD write in the expiry cycle restarts the count instead of expiring
  assign expire    = !tload_wr && (tcnt == 32'd1);
  assign timer_irq = tstat;

  // Interval timer: reload/decrement and sticky expiry flag (expiry wins over clear)
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tload <= 32'd0;
      tcnt  <= 32'd0;
      tstat <= 1'b0;
    end else begin
      if (tload_wr) begin
        tload <= datain;
        tcnt  <= datain;
      end else if (tcnt == 32'd1) begin
        tcnt <= tload;
      end else if (tcnt != 32'd0) begin
        tcnt <= tcnt - 32'd1;
      end
      if (expire) begin
        tstat <= 1'b1;
      end else if (we && is_io && (off == OFF_TSTAT) && datain[0]) begin
        tstat <= 1'b0;
      end
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // Load path is purely combinational so the MEM stage sees data in the same cycle
  always_comb begin
    io_rd = 32'd0;
    case (off)
      OFF_OUT:   io_rd = io_out;
      OFF_IN:    io_rd = sync2;
      OFF_CYC:   io_rd = cyc;
`ifdef PIPE_DATAMEM_TIMER_EN
      OFF_TLOAD: io_rd = tload;
      OFF_TCNT:  io_rd = tcnt;
      OFF_TSTAT: io_rd = {31'd0, tstat};
`endif
      default:   io_rd = 32'd0;
    endcase
    if (is_io) begin
      dataout = io_rd;
    end else begin
      dataout = mem[widx];
    end
  end

endmodule

// File: tb/tb_pipe_datamem.sv
// Self-checking bench for pipe_datamem: directed spec scenarios, then random traffic
// compared against a behavioural model of the memory map.
module tb_pipe_datamem;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;
  logic [31:0] io_in;
  logic [31:0] io_out;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  // behavioural model state
  logic [31:0] m_mem [32];
  bit          m_valid [32];
  logic [31:0] m_out, m_s1, m_s2, m_cyc, m_tload, m_tcnt;
  bit          m_tstat;

  pipe_datamem #(.DEPTH_LOG2(5)) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .we(we),
    .dataout(dataout), .io_in(io_in), .io_out(io_out), .timer_irq(timer_irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_known(input logic [31:0] a);
    return a[7] || m_valid[a[6:2]];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a);
    if (!a[7]) return m_mem[a[6:2]];
    case (a[6:0])
      7'h00: return m_out;
      7'h04: return m_s2;
      7'h08: return m_cyc;
`ifdef PIPE_DATAMEM_TIMER_EN
      7'h0C: return m_tload;
      7'h10: return m_tcnt;
      7'h14: return {31'd0, m_tstat};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_irq();
`ifdef PIPE_DATAMEM_TIMER_EN
    return m_tstat;
`else
    return 1'b0;
`endif
  endfunction

  // advance the model by one rising edge using the inputs currently applied
  task automatic model_edge();
    bit io_w;
    bit expired;
    io_w = we && addr[7];
    if (!resetn) begin
      m_out = 32'd0; m_s1 = 32'd0; m_s2 = 32'd0; m_cyc = 32'd0;
      m_tload = 32'd0; m_tcnt = 32'd0; m_tstat = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = io_in;
      m_cyc = (io_w && addr[6:0] == 7'h08) ? 32'd0 : m_cyc + 32'd1;
      if (io_w && addr[6:0] == 7'h00) m_out = datain;
      if (we && !addr[7]) begin
        m_mem[addr[6:2]] = datain;
        m_valid[addr[6:2]] = 1'b1;
      end
      expired = 1'b0;
      if (io_w && addr[6:0] == 7'h0C) begin
        m_tload = datain;
        m_tcnt = datain;
      end else if (m_tcnt == 32'd1) begin
        m_tcnt = m_tload;
        expired = 1'b1;
      end else if (m_tcnt != 32'd0) begin
        m_tcnt = m_tcnt - 32'd1;
      end
      if (expired) m_tstat = 1'b1;
      else if (io_w && addr[6:0] == 7'h14 && datain[0]) m_tstat = 1'b0;
    end
  endtask

  // apply one access, check outputs mid-cycle, then take the edge
  task automatic cycle(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w);
    resetn = r; addr = a; datain = d; we = w;
    #3;
    if (armed) begin
      if (model_known(a)) check_val("dataout", dataout, model_load(a));
      check_val("io_out", io_out, m_out);
      check_val("timer_irq", {31'd0, timer_irq}, {31'd0, model_irq()});
    end
    @(posedge clock);
    model_edge();
    armed = 1'b1;
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0;
    #1;
    check_val(tag, dataout, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic w, r;
    resetn = 1'b0; addr = 32'h0; datain = 32'h0; we = 1'b0; io_in = 32'h0;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;

    // reset beats a concurrent OUT store
    cycle(1'b0, 32'h80, 32'hFF, 1'b1);
    cycle(1'b0, 32'h80, 32'hFF, 1'b1);
    check_val("reset_io_out", io_out, 32'h0);
    check_val("reset_irq", {31'd0, timer_irq}, 32'd0);

    for (int i = 0; i < 32; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b1);

    // cycle counter counts edges since reset
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h88, 32'h0, 1'b0);
    peek("cyc_10", 32'h88, 32'd10);
    cycle(1'b1, 32'h88, 32'h1234, 1'b1);
    peek("cyc_clear", 32'h88, 32'd0);
    force dut.cyc = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    peek("cyc_max", 32'h88, 32'hFFFF_FFFF);
    release dut.cyc;
    idle(1);
    peek("cyc_wrap", 32'h88, 32'd0);

    // RAM store, aliasing, old-value read during the store
    cycle(1'b1, 32'h14, 32'hDEADBEEF, 1'b1);
    peek("ram_load", 32'h14, 32'hDEADBEEF);
    peek("ram_alias", 32'h114, 32'hDEADBEEF);

    cycle(1'b1, 32'h80, 32'hA5, 1'b1);
    check_val("out_a5", io_out, 32'hA5);
    cycle(1'b0, 32'h80, 32'hFF, 1'b1);
    check_val("out_reset", io_out, 32'h0);
    peek("ram_keep", 32'h14, 32'hDEADBEEF);

    // input synchroniser latency
    io_in = 32'h0;
    idle(2);
    io_in = 32'h12345678;
    idle(1);
    peek("in_1edge", 32'h84, 32'h0);
    idle(1);
    peek("in_2edge", 32'h84, 32'h12345678);

`ifdef PIPE_DATAMEM_TIMER_EN
    cycle(1'b1, 32'h8C, 32'd3, 1'b1);
    idle(2);
    check_val("tmr_pre", {31'd0, timer_irq}, 32'd0);
    idle(1);
    check_val("tmr_expire", {31'd0, timer_irq}, 32'd1);
    peek("tmr_reload", 32'h90, 32'd3);
    idle(2);
    cycle(1'b1, 32'h94, 32'd1, 1'b1);
    check_val("tmr_clr_vs_exp", {31'd0, timer_irq}, 32'd1);
    cycle(1'b1, 32'h94, 32'd1, 1'b1);
    check_val("tmr_clr", {31'd0, timer_irq}, 32'd0);
    cycle(1'b1, 32'h8C, 32'd0, 1'b1);
    peek("tmr_stop_cnt", 32'h90, 32'd0);
    idle(8);
    check_val("tmr_stopped", {31'd0, timer_irq}, 32'd0);
`else
    cycle(1'b1, 32'h8C, 32'd5, 1'b1);
    cycle(1'b1, 32'h90, 32'd5, 1'b1);
    cycle(1'b1, 32'h94, 32'd5, 1'b1);
    peek("notmr_8c", 32'h8C, 32'd0);
    peek("notmr_90", 32'h90, 32'd0);
    peek("notmr_94", 32'h94, 32'd0);
    idle(4);
    check_val("notmr_irq", {31'd0, timer_irq}, 32'd0);
`endif

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = $urandom & 32'hFFFF_FF7F;
        2:       a = ($urandom & 32'hFFFF_FF00) | 32'h80 | 32'($urandom_range(0, 7) * 4);
        default: a = $urandom | 32'h80;
      endcase
      d = $urandom;
      if (a[7] && a[6:0] == 7'h0C) d = 32'($urandom_range(0, 6));
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 4) == 0) io_in = $urandom;
      cycle(r, a, d, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
